// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the master FSM state type.
// Used by ahb_lite_master and by the SRAM-backed slave on the same bus.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // ST_ERR     : between the first and second cycle of an ERROR response
  // ST_REISSUE : replaying an address phase that was cancelled by an ERROR
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ERR     = 2'd1,
    ST_REISSUE = 2'd2
  } ahb_mst_state_e;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready stream of single-word read/write
// commands into pipelined NONSEQ SINGLE transfers and returns one response
// (read data + error flag) per command, in command order.
//
// Ports
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata  command payload; cmd_addr[1:0] ignored
//   rsp_valid/rdata/err   one-cycle response pulse, no backpressure
//   HADDR..HWDATA         registered AHB-Lite master outputs
//   HRDATA/HREADY/HRESP   AHB-Lite slave inputs
//
// Build option
//   AHB_MASTER_ERR_CANCEL_EN : on the first ERROR cycle a pending NONSEQ
//   address phase is dropped to IDLE and replayed once the error completes.
//   Without it the pending address phase simply continues.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

`ifdef AHB_MASTER_ERR_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  ahb_mst_state_e    state_q, state_d;
  logic [DATA_W-1:0] wdata_q;   // write data of the transfer in address phase
  logic              dp_act_q;  // a transfer is in its data phase
  logic              dp_wr_q;
  logic              cancel_q;  // address phase was dropped by an ERROR
  logic              accept, addr_nonseq, err_first;

  assign HSIZE       = HSIZE_WORD;
  assign HBURST      = HBURST_SINGLE;
  assign cmd_ready   = HRESETn && HREADY && (state_q == ST_RUN);
  assign accept      = cmd_valid && cmd_ready;
  assign addr_nonseq = (HTRANS == HTRANS_NONSEQ);
  // first cycle of a two-cycle ERROR response
  assign err_first   = dp_act_q && (HRESP == HRESP_ERROR) && !HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (err_first) state_d = ST_ERR;
      ST_ERR:     if (HREADY)    state_d = cancel_q ? ST_REISSUE : ST_RUN;
      ST_REISSUE: if (HREADY)    state_d = ST_RUN;
      default:                   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      wdata_q   <= '0;
      dp_act_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      cancel_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (HREADY) begin
        // data phase completes
        if (dp_act_q) begin
          rsp_valid <= 1'b1;
          rsp_err   <= HRESP;
          rsp_rdata <= dp_wr_q ? '0 : HRDATA;
        end
        // address phase completes into data phase
        dp_act_q <= addr_nonseq;
        if (addr_nonseq) begin
          dp_wr_q <= HWRITE;
          HWDATA  <= wdata_q;
        end
        // next address phase
        if (accept) begin
          HTRANS  <= HTRANS_NONSEQ;
          HADDR   <= cmd_addr & WORD_MASK;
          HWRITE  <= cmd_write;
          wdata_q <= cmd_wdata;
        end else if (state_q == ST_ERR && cancel_q) begin
          HTRANS  <= HTRANS_NONSEQ;  // replay held HADDR/HWRITE/wdata
        end else begin
          HTRANS  <= HTRANS_IDLE;
        end
        cancel_q <= 1'b0;
      end else if (CANCEL_EN && err_first && state_q == ST_RUN && addr_nonseq) begin
        HTRANS   <= HTRANS_IDLE;
        cancel_q <= 1'b1;
      end
    end
  end

endmodule
